// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: one requester's request/response channel into the shared ALU arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       opcode;
    logic [15:0]      in1;
    logic [15:0]      in2;
    logic [TAG_W-1:0] tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport master (
        output req_valid, opcode, in1, in2, tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
    );

    modport slave (
        input  req_valid, opcode, in1, in2, tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 16-bit ALU between requester r0 (execute path)
// and r1 (address/auxiliary path) with round-robin arbitration, holds operands on the
// ALU for ISSUE_CYC cycles, returns a registered result/tag to the owner and keeps the
// architectural {V,Z,C,S} flag register.
// Optional macro ALU_ARB_OPCHK_EN: opcodes 7, 13, 14, 15 are accepted but not sent to
// the ALU and come back with rsp_err=1, rsp_data=0.
module alu_arbiter #(
    parameter int TAG_W     = 4,
    parameter int ISSUE_CYC = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave r0,
    alu_arbiter_if.slave r1,
    output logic [3:0]   alu_opcode,
    output logic [15:0]  alu_in1,
    output logic [15:0]  alu_in2,
    input  logic [16:0]  alu_result,
    input  logic         alu_v,
    input  logic         alu_z,
    input  logic         alu_c,
    input  logic         alu_s,
    output logic [3:0]   flags_q,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ISSUE_CYC - 1);

    state_t           state;
    state_t           state_nxt;

    logic             last_grant;   // 1 = r1 was served last, so r0 wins the next tie
    logic             owner;        // requester holding the ALU
    logic [3:0]       op_q;
    logic [15:0]      in1_q;
    logic [15:0]      in2_q;
    logic [TAG_W-1:0] tag_q;
    logic [3:0]       cnt_q;
    logic [15:0]      data_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             err_q;

    logic             in_idle;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             capture;
    logic             rsp_done;
    logic             op_bad;
    logic             drive_alu;
    logic             unused_result_msb;

    // Only the low 16 bits of the ALU result are architectural.
    assign unused_result_msb = alu_result[16];

    // Opcodes that load the flag register at capture; mov (6), in (12) and the
    // reserved opcodes leave it alone.
    function automatic logic sets_flags(input logic [3:0] op);
        return (op <= 4'd5) || ((op >= 4'd8) && (op <= 4'd11));
    endfunction

`ifdef ALU_ARB_OPCHK_EN
    assign op_bad = (op_q == 4'd7) || (op_q >= 4'd13);
`else
    assign op_bad = 1'b0;
`endif

    // Round-robin: a lone requester is always granted; on a tie the one not served last wins.
    assign in_idle  = (state == IDLE) && rst_n;
    assign grant0   = r0.req_valid && (!r1.req_valid || last_grant);
    assign grant1   = r1.req_valid && (!r0.req_valid || !last_grant);
    assign accept   = in_idle && (grant0 || grant1);
    assign capture  = (state == ISSUE) && (cnt_q == 4'd0);
    assign rsp_done = (state == RESP) && (owner ? r1.rsp_ready : r0.rsp_ready);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: IDLE -> ISSUE on accept, ISSUE -> RESP when the hold count expires,
    // RESP -> IDLE when the owner takes the response.
    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a path that
        // does not assign it infers a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = ISSUE;
            ISSUE:   if (capture)  state_nxt = RESP;
            RESP:    if (rsp_done) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Transaction datapath: latch the granted request, count the ALU hold time,
    // capture result/tag/flags at the end of ISSUE.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_q       <= 4'd0;
            in1_q      <= 16'd0;
            in2_q      <= 16'd0;
            tag_q      <= '0;
            cnt_q      <= 4'd0;
            data_q     <= 16'd0;
            rsp_tag_q  <= '0;
            err_q      <= 1'b0;
            flags_q    <= 4'd0;
        end else begin
            if (accept) begin
                owner      <= grant1;
                last_grant <= grant1;
                op_q       <= grant1 ? r1.opcode : r0.opcode;
                in1_q      <= grant1 ? r1.in1    : r0.in1;
                in2_q      <= grant1 ? r1.in2    : r0.in2;
                tag_q      <= grant1 ? r1.tag    : r0.tag;
                cnt_q      <= CNT_INIT;
            end
            if ((state == ISSUE) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                data_q    <= op_bad ? 16'd0 : alu_result[15:0];
                rsp_tag_q <= tag_q;
                err_q     <= op_bad;
                // Reserved opcodes are outside the flag-setting set, so errored ops
                // never reach this load.
                if (sets_flags(op_q)) begin
                    flags_q <= {alu_v, alu_z, alu_c, alu_s};
                end
            end
        end
    end

    // Output decode: grants in IDLE, operands on the ALU while an op is in flight,
    // response presented only on the owner's port during RESP.
    always_comb begin
        busy          = (state != IDLE);
        drive_alu     = (state != IDLE) && !op_bad;
        alu_opcode    = drive_alu ? op_q  : 4'd0;
        alu_in1       = drive_alu ? in1_q : 16'd0;
        alu_in2       = drive_alu ? in2_q : 16'd0;

        r0.req_ready  = in_idle && grant0;
        r1.req_ready  = in_idle && grant1;

        r0.rsp_valid  = (state == RESP) && !owner;
        r1.rsp_valid  = (state == RESP) && owner;
        r0.rsp_data   = r0.rsp_valid ? data_q    : 16'd0;
        r1.rsp_data   = r1.rsp_valid ? data_q    : 16'd0;
        r0.rsp_tag    = r0.rsp_valid ? rsp_tag_q : '0;
        r1.rsp_tag    = r1.rsp_valid ? rsp_tag_q : '0;
        r0.rsp_err    = r0.rsp_valid && err_q;
        r1.rsp_err    = r1.rsp_valid && err_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter.
// dut uses ISSUE_CYC=1, dut3 uses ISSUE_CYC=3. Expected results for the
// ALU_ARB_OPCHK_EN build are selected when that macro is defined.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.TAG_W(4)) r0_if ();
    alu_arbiter_if #(.TAG_W(4)) r1_if ();
    alu_arbiter_if #(.TAG_W(4)) a0_if ();
    alu_arbiter_if #(.TAG_W(4)) a1_if ();

    logic [3:0]  alu_opcode,   b_alu_opcode;
    logic [15:0] alu_in1,      b_alu_in1;
    logic [15:0] alu_in2,      b_alu_in2;
    logic [16:0] alu_result,   b_alu_result;
    logic        alu_v, alu_z, alu_c, alu_s;
    logic        b_alu_v, b_alu_z, b_alu_c, b_alu_s;
    logic [3:0]  flags_q,      b_flags_q;
    logic        busy,         b_busy;

`ifdef ALU_ARB_OPCHK_EN
    localparam logic       EXP_ERR13 = 1'b1;
    localparam logic [3:0] EXP_OP13  = 4'd0;
`else
    localparam logic       EXP_ERR13 = 1'b0;
    localparam logic [3:0] EXP_OP13  = 4'd13;
`endif

    // Stand-in combinational ALU: {V,Z,C,S,result[16:0]}.
    function automatic logic [20:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        logic        v;
        r = 17'd0;
        v = 1'b0;
        case (op)
            4'd0: begin r = {1'b0, a} + {1'b0, b}; v = (a[15] == b[15]) && (r[15] != a[15]); end
            4'd1: begin r = {1'b0, a} - {1'b0, b}; v = (a[15] != b[15]) && (r[15] != a[15]); end
            4'd2: r = {1'b0, a & b};
            4'd3: r = {1'b0, a | b};
            4'd4: r = {1'b0, a ^ b};
            4'd6: r = {1'b0, a};
            default: r = 17'd0;
        endcase
        return {v, (r[15:0] == 16'd0), r[16], r[15], r};
    endfunction

    assign {alu_v, alu_z, alu_c, alu_s, alu_result}         = alu_model(alu_opcode, alu_in1, alu_in2);
    assign {b_alu_v, b_alu_z, b_alu_c, b_alu_s, b_alu_result} = alu_model(b_alu_opcode, b_alu_in1, b_alu_in2);

    alu_arbiter #(.TAG_W(4), .ISSUE_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .r0(r0_if), .r1(r1_if),
        .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_result(alu_result), .alu_v(alu_v), .alu_z(alu_z), .alu_c(alu_c), .alu_s(alu_s),
        .flags_q(flags_q), .busy(busy)
    );

    alu_arbiter #(.TAG_W(4), .ISSUE_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .r0(a0_if), .r1(a1_if),
        .alu_opcode(b_alu_opcode), .alu_in1(b_alu_in1), .alu_in2(b_alu_in2),
        .alu_result(b_alu_result), .alu_v(b_alu_v), .alu_z(b_alu_z), .alu_c(b_alu_c), .alu_s(b_alu_s),
        .flags_q(b_flags_q), .busy(b_busy)
    );

    task automatic drive(input bit sel, input logic v, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
        if (sel) begin
            r1_if.req_valid = v; r1_if.opcode = op; r1_if.in1 = a; r1_if.in2 = b; r1_if.tag = t;
        end else begin
            r0_if.req_valid = v; r0_if.opcode = op; r0_if.in1 = a; r0_if.in2 = b; r0_if.tag = t;
        end
    endtask

    // One request on dut; returns at the negedge where rsp_valid is first seen.
    // lat counts cycles from the accept cycle; op_seen is alu_opcode in the first ISSUE cycle.
    task automatic req(input bit sel, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] t, output int lat, output logic [3:0] op_seen);
        int waits;
        lat     = -1;
        op_seen = 4'hx;
        @(negedge clk);
        drive(sel, 1'b1, op, a, b, t);
        #1;
        waits = 0;
        while (!(sel ? r1_if.req_ready : r0_if.req_ready) && waits < 20) begin
            @(negedge clk); #1; waits++;
        end
        if (!(sel ? r1_if.req_ready : r0_if.req_ready)) begin
            checks++; errors++;
            $display("FAIL req_accept r%0d: req_ready still 0 after 20 cycles", sel);
            drive(sel, 1'b0, op, a, b, t);
            return;
        end
        @(negedge clk);
        drive(sel, 1'b0, op, a, b, t);
        op_seen = alu_opcode;
        lat = 1;
        while (!(sel ? r1_if.rsp_valid : r0_if.rsp_valid) && lat < 30) begin
            @(negedge clk); lat++;
        end
    endtask

    // Same as req, on dut3 requester 0.
    task automatic req_b(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] t, output int lat, output logic [3:0] op_seen);
        int waits;
        lat     = -1;
        op_seen = 4'hx;
        @(negedge clk);
        a0_if.req_valid = 1'b1; a0_if.opcode = op; a0_if.in1 = a; a0_if.in2 = b; a0_if.tag = t;
        #1;
        waits = 0;
        while (!a0_if.req_ready && waits < 20) begin
            @(negedge clk); #1; waits++;
        end
        if (!a0_if.req_ready) begin
            checks++; errors++;
            $display("FAIL req_b_accept: req_ready still 0 after 20 cycles");
            a0_if.req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        a0_if.req_valid = 1'b0;
        op_seen = b_alu_opcode;
        lat = 1;
        while (!a0_if.rsp_valid && lat < 30) begin
            @(negedge clk); lat++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 4'd0, 16'd1, 16'd1, 4'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (r0_if.req_ready !== 1'b0) begin errors++; $display("FAIL reset_r0_ready got=%b exp=0", r0_if.req_ready); end
        checks++;
        if ({r0_if.rsp_valid, r1_if.rsp_valid, r0_if.rsp_err, r1_if.rsp_err, r1_if.req_ready} !== 5'd0) begin
            errors++; $display("FAIL reset_rsp_flags got=%b exp=00000",
                {r0_if.rsp_valid, r1_if.rsp_valid, r0_if.rsp_err, r1_if.rsp_err, r1_if.req_ready});
        end
        checks++;
        if ({r0_if.rsp_data, r0_if.rsp_tag, r1_if.rsp_data, r1_if.rsp_tag} !== 40'd0) begin
            errors++; $display("FAIL reset_rsp_data got=%h exp=0",
                {r0_if.rsp_data, r0_if.rsp_tag, r1_if.rsp_data, r1_if.rsp_tag});
        end
        checks++;
        if ({alu_opcode, alu_in1, alu_in2} !== 36'd0) begin
            errors++; $display("FAIL reset_alu got=%h exp=0", {alu_opcode, alu_in1, alu_in2});
        end
        checks++;
        if ({flags_q, busy} !== 5'd0) begin errors++; $display("FAIL reset_flags_busy got=%b exp=00000", {flags_q, busy}); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (r0_if.req_ready !== 1'b1) begin errors++; $display("FAIL idle_r0_ready got=%b exp=1", r0_if.req_ready); end
        // Withdraw before the edge: nothing may be accepted.
        drive(1'b0, 1'b0, 4'd0, 16'd1, 16'd1, 4'd1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL withdraw_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_add();
        int lat;
        logic [3:0] op_seen;
        req(1'b0, 4'd0, 16'h7FFF, 16'h0001, 4'd3, lat, op_seen);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL add_latency got=%0d exp=2", lat); end
        checks++;
        if (op_seen !== 4'd0) begin errors++; $display("FAIL add_alu_opcode got=%h exp=0", op_seen); end
        checks++;
        if (r0_if.rsp_data !== 16'h8000) begin errors++; $display("FAIL add_data got=%h exp=8000", r0_if.rsp_data); end
        checks++;
        if (r0_if.rsp_tag !== 4'd3) begin errors++; $display("FAIL add_tag got=%h exp=3", r0_if.rsp_tag); end
        checks++;
        if ({r1_if.rsp_valid, r0_if.rsp_err} !== 2'b00) begin
            errors++; $display("FAIL add_r1_valid_err got=%b exp=00", {r1_if.rsp_valid, r0_if.rsp_err});
        end
        checks++;
        if (flags_q !== 4'b1001) begin errors++; $display("FAIL add_flags got=%b exp=1001", flags_q); end
    endtask

    task automatic test_rotation();
        bit found;
        apply_reset();
        drive(1'b0, 1'b1, 4'd0, 16'h0001, 16'h0002, 4'h5);
        drive(1'b1, 1'b1, 4'd3, 16'h00F0, 16'h0F00, 4'hA);
        for (int i = 0; i < 4; i++) begin
            found = 1'b0;
            for (int k = 0; k < 20 && !found; k++) begin
                @(negedge clk);
                if (r0_if.rsp_valid || r1_if.rsp_valid) found = 1'b1;
            end
            checks++;
            if (!found) begin errors++; $display("FAIL rot%0d_timeout no response within 20 cycles", i); end
            checks++;
            if ({r1_if.rsp_valid, r0_if.rsp_valid} !== ((i % 2) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rot%0d_owner got={r1,r0}=%b exp=%b", i,
                    {r1_if.rsp_valid, r0_if.rsp_valid}, ((i % 2) ? 2'b10 : 2'b01));
            end
            if (i % 2) begin
                checks++;
                if (r1_if.rsp_data !== 16'h0FF0) begin errors++; $display("FAIL rot%0d_data got=%h exp=0ff0", i, r1_if.rsp_data); end
                checks++;
                if (r1_if.rsp_tag !== 4'hA) begin errors++; $display("FAIL rot%0d_tag got=%h exp=a", i, r1_if.rsp_tag); end
            end else begin
                checks++;
                if (r0_if.rsp_data !== 16'h0003) begin errors++; $display("FAIL rot%0d_data got=%h exp=0003", i, r0_if.rsp_data); end
                checks++;
                if (r0_if.rsp_tag !== 4'h5) begin errors++; $display("FAIL rot%0d_tag got=%h exp=5", i, r0_if.rsp_tag); end
            end
        end
        drive(1'b0, 1'b0, 4'd0, 16'd0, 16'd0, 4'd0);
        drive(1'b1, 1'b0, 4'd0, 16'd0, 16'd0, 4'd0);
    endtask

    task automatic test_backpressure();
        int lat;
        logic [3:0] op_seen;
        bit found;
        @(negedge clk);
        r1_if.rsp_ready = 1'b0;
        req(1'b1, 4'd2, 16'hF0F0, 16'hFF00, 4'd6, lat, op_seen);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL bp_latency got=%0d exp=2", lat); end
        drive(1'b0, 1'b1, 4'd0, 16'h0001, 16'h0001, 4'd1);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if ({r1_if.rsp_valid, r1_if.rsp_data, r1_if.rsp_tag} !== {1'b1, 16'hF000, 4'd6}) begin
                errors++; $display("FAIL bp_hold%0d got valid=%b data=%h tag=%h exp valid=1 data=f000 tag=6",
                    k, r1_if.rsp_valid, r1_if.rsp_data, r1_if.rsp_tag);
            end
            checks++;
            if (r0_if.req_ready !== 1'b0) begin errors++; $display("FAIL bp_r0_ready%0d got=%b exp=0", k, r0_if.req_ready); end
            @(negedge clk);
        end
        checks++;
        if (flags_q !== 4'b0001) begin errors++; $display("FAIL bp_flags got=%b exp=0001", flags_q); end
        r1_if.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({r1_if.rsp_valid, busy, r0_if.req_ready} !== 3'b001) begin
            errors++; $display("FAIL bp_release got={rsp_valid,busy,r0_ready}=%b exp=001",
                {r1_if.rsp_valid, busy, r0_if.req_ready});
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 16'h0001, 16'h0001, 4'd1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (r0_if.rsp_valid) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if ({found, r0_if.rsp_data, r0_if.rsp_tag} !== {1'b1, 16'h0002, 4'd1}) begin
            errors++; $display("FAIL bp_next got found=%b data=%h tag=%h exp found=1 data=0002 tag=1",
                found, r0_if.rsp_data, r0_if.rsp_tag);
        end
    endtask

    task automatic test_flag_hold();
        int lat;
        logic [3:0] op_seen;
        req(1'b0, 4'd1, 16'd5, 16'd5, 4'd7, lat, op_seen);
        checks++;
        if ({r0_if.rsp_data, flags_q} !== {16'h0000, 4'b0100}) begin
            errors++; $display("FAIL sub_zero got data=%h flags=%b exp data=0000 flags=0100", r0_if.rsp_data, flags_q);
        end
        req(1'b0, 4'd6, 16'h1234, 16'h1234, 4'd8, lat, op_seen);
        checks++;
        if (r0_if.rsp_data !== 16'h1234) begin errors++; $display("FAIL mov_data got=%h exp=1234", r0_if.rsp_data); end
        checks++;
        if (flags_q !== 4'b0100) begin errors++; $display("FAIL mov_flags got=%b exp=0100", flags_q); end
    endtask

    task automatic test_bad_opcode();
        int lat;
        logic [3:0] op_seen;
        req(1'b1, 4'd13, 16'hAAAA, 16'h5555, 4'd9, lat, op_seen);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL op13_latency got=%0d exp=2", lat); end
        checks++;
        if (op_seen !== EXP_OP13) begin errors++; $display("FAIL op13_alu_opcode got=%h exp=%h", op_seen, EXP_OP13); end
        checks++;
        if ({r1_if.rsp_err, r1_if.rsp_data, r1_if.rsp_tag} !== {EXP_ERR13, 16'h0000, 4'd9}) begin
            errors++; $display("FAIL op13_rsp got err=%b data=%h tag=%h exp err=%b data=0000 tag=9",
                r1_if.rsp_err, r1_if.rsp_data, r1_if.rsp_tag, EXP_ERR13);
        end
        checks++;
        if (flags_q !== 4'b0100) begin errors++; $display("FAIL op13_flags got=%b exp=0100", flags_q); end
    endtask

    task automatic test_issue_cyc3();
        int lat;
        logic [3:0] op_seen;
        req_b(4'd0, 16'hFFFF, 16'h0001, 4'd4, lat, op_seen);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL ic3_add_latency got=%0d exp=4", lat); end
        checks++;
        if ({a0_if.rsp_data, a0_if.rsp_tag, a0_if.rsp_err, b_flags_q} !== {16'h0000, 4'd4, 1'b0, 4'b0110}) begin
            errors++; $display("FAIL ic3_add got data=%h tag=%h err=%b flags=%b exp data=0000 tag=4 err=0 flags=0110",
                a0_if.rsp_data, a0_if.rsp_tag, a0_if.rsp_err, b_flags_q);
        end
        req_b(4'd13, 16'h1111, 16'h2222, 4'd2, lat, op_seen);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL ic3_op13_latency got=%0d exp=4", lat); end
        checks++;
        if (op_seen !== EXP_OP13) begin errors++; $display("FAIL ic3_op13_alu_opcode got=%h exp=%h", op_seen, EXP_OP13); end
        checks++;
        if ({a0_if.rsp_err, a0_if.rsp_data, a0_if.rsp_tag, b_flags_q} !== {EXP_ERR13, 16'h0000, 4'd2, 4'b0110}) begin
            errors++; $display("FAIL ic3_op13 got err=%b data=%h tag=%h flags=%b exp err=%b data=0000 tag=2 flags=0110",
                a0_if.rsp_err, a0_if.rsp_data, a0_if.rsp_tag, b_flags_q, EXP_ERR13);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 4'd0, 16'd0, 16'd0, 4'd0);
        drive(1'b1, 1'b0, 4'd0, 16'd0, 16'd0, 4'd0);
        r0_if.rsp_ready = 1'b1;
        r1_if.rsp_ready = 1'b1;
        a0_if.req_valid = 1'b0; a0_if.opcode = 4'd0; a0_if.in1 = 16'd0; a0_if.in2 = 16'd0; a0_if.tag = 4'd0;
        a0_if.rsp_ready = 1'b1;
        a1_if.req_valid = 1'b0; a1_if.opcode = 4'd0; a1_if.in1 = 16'd0; a1_if.in2 = 16'd0; a1_if.tag = 4'd0;
        a1_if.rsp_ready = 1'b1;

        test_reset();
        test_single_add();
        test_rotation();
        test_backpressure();
        test_flag_hold();
        test_bad_opcode();
        test_issue_cyc3();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
